// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: cycles through digits with a
// blank gap between them and swaps in newly loaded data only at frame start.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_data,
    input  logic                    lz_en,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DISP_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        DISP,
        BLANK
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0] active, active_nxt;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
    logic                    pending_nxt;
    logic                    commit;
    logic [NUM_DIGITS-1:0]   sup;
    logic                    all_zero;
    logic [3:0]              nib_sel;
    logic                    sup_sel;
    logic [NUM_DIGITS-1:0]   dig_en_nxt;
    logic [3:0]              bcd_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= IDX_LAST;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            dig_en     <= '0;
            bcd_out    <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            active     <= active_nxt;
            shadow     <= shadow_nxt;
            pending    <= pending_nxt;
            dig_en     <= dig_en_nxt;
            bcd_out    <= bcd_nxt;
            frame_done <= commit;
        end
    end

    // Outputs are computed from next-state values so the registered outputs
    // always describe the state held in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        commit    = 1'b0;

        case (state)
            DISP: begin
                if (cnt == DISP_LAST) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = DISP;
                    cnt_nxt   = '0;
                    commit    = (idx == IDX_LAST);
                    idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase

        shadow_nxt = load ? bcd_data : shadow;

        // A load landing on the commit edge bypasses the shadow entirely.
        active_nxt = active;
        if (commit) begin
            if (load) begin
                active_nxt = bcd_data;
            end else if (pending) begin
                active_nxt = shadow;
            end
        end

        pending_nxt = commit ? 1'b0 : (load ? 1'b1 : pending);

        sup      = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero & (active_nxt[4*k +: 4] == 4'h0);
            sup[k]   = all_zero;
        end

        nib_sel    = 4'hF;
        sup_sel    = 1'b0;
        dig_en_nxt = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nxt == IW'(k)) begin
                nib_sel       = active_nxt[4*k +: 4];
                sup_sel       = sup[k] && (k != 0);
                dig_en_nxt[k] = (state_nxt == DISP);
            end
        end

        bcd_nxt = 4'hF;
        if (state_nxt == DISP && !(lz_en && sup_sel)) begin
            bcd_nxt = nib_sel;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues expected digit codes,
// a negedge monitor pops them at each digit start and checks scan timing.
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [4*N-1:0] bcd_data = '0;
    logic          lz_en = 1'b0;
    logic [3:0]    bcd_out;
    logic [N-1:0]  dig_en;
    logic          pending;
    logic          frame_done;

    seg7_scan_ctrl #(
        .NUM_DIGITS(N),
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .bcd_data  (bcd_data),
        .lz_en     (lz_en),
        .bcd_out   (bcd_out),
        .dig_en    (dig_en),
        .pending   (pending),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] den;
        logic [3:0] bcd;
        logic       fd;
        logic       sync;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    bit   mon_on = 1'b0;
    logic [N-1:0] prev_den = '0;
    int   run_len = 0;
    bit   run_rst = 1'b1;
    int   fd_gap = 0;
    bit   fd_armed = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [4*N-1:0] d);
        bcd_data = d;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic pushExp(input logic [3:0] den, input logic [3:0] bcd, input logic fd, input logic sync);
        exp_t e;
        e.den  = den;
        e.bcd  = bcd;
        e.fd   = fd;
        e.sync = sync;
        sbq.push_back(e);
    endtask

    // Codes are the hand-computed displayed values, digit k in nibble k.
    task automatic pushFrame(input logic [15:0] codes);
        pushExp(4'b0001, codes[3:0],   1'b1, 1'b1);
        pushExp(4'b0010, codes[7:4],   1'b0, 1'b0);
        pushExp(4'b0100, codes[11:8],  1'b0, 1'b0);
        pushExp(4'b1000, codes[15:12], 1'b0, 1'b0);
    endtask

    task automatic waitDrain;
        int i;
        i = 0;
        while (sbq.size() != 0 && i < 200) begin
            tick();
            i++;
        end
        checkOutput("drain_timeout", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic waitDen(input logic [3:0] d);
        int i;
        i = 0;
        while (dig_en != d && i < 100) begin
            tick();
            i++;
        end
        checkOutput("wait_den_timeout", (dig_en == d), 1);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (dig_en == '0) checkOutput("blank_code", bcd_out, 4'hF);
            checkOutput("onehot", ($countones(dig_en) <= 1), 1);

            if (dig_en != prev_den) begin
                if (!run_rst) begin
                    if (prev_den != '0) checkOutput("disp_len", run_len, SD);
                    else                checkOutput("blank_len", run_len, BC);
                end
                run_len = 1;
                run_rst = !rst_n;
            end else begin
                run_len++;
                if (!rst_n) run_rst = 1'b1;
            end

            if (!rst_n) fd_armed = 1'b0;
            if (frame_done) begin
                checkOutput("fd_digit", dig_en, 4'b0001);
                checkOutput("fd_first", prev_den, 4'b0000);
                if (fd_armed) checkOutput("frame_period", fd_gap, N * (SD + BC));
                fd_armed = 1'b1;
                fd_gap   = 0;
            end
            fd_gap++;

            if (dig_en != '0 && prev_den == '0 && sbq.size() > 0) begin
                if (!(sbq[0].sync && !frame_done)) begin
                    mon_e = sbq.pop_front();
                    checkOutput("sb_digit", dig_en, mon_e.den);
                    checkOutput("sb_code", bcd_out, mon_e.bcd);
                    checkOutput("sb_fd", frame_done, mon_e.fd);
                end
            end
            prev_den = dig_en;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick();
        mon_on = 1'b1;
        tick();
        tick();
        checkOutput("rst_den", dig_en, 4'b0000);
        checkOutput("rst_bcd", bcd_out, 4'hF);
        checkOutput("rst_fd", frame_done, 1'b0);
        checkOutput("rst_pend", pending, 1'b0);

        rst_n = 1'b1;
        tick();
        checkOutput("rel1_den", dig_en, 4'b0000);
        checkOutput("rel1_fd", frame_done, 1'b0);
        tick();
        checkOutput("rel2_den", dig_en, 4'b0001);
        checkOutput("rel2_bcd", bcd_out, 4'h0);
        checkOutput("rel2_fd", frame_done, 1'b1);
        tick();
        checkOutput("rel3_fd", frame_done, 1'b0);
        checkOutput("rel3_den", dig_en, 4'b0001);

        applyStimulus(16'h1234);
        checkOutput("scan_pend_set", pending, 1'b1);
        pushFrame(16'h1234);
        pushFrame(16'h1234);
        waitDrain();
        checkOutput("scan_pend_clr", pending, 1'b0);

        lz_en = 1'b1;
        applyStimulus(16'h0050);
        pushFrame(16'hFF50);
        waitDrain();
        applyStimulus(16'h0000);
        pushFrame(16'hFFF0);
        waitDrain();
        applyStimulus(16'h0A00);
        pushFrame(16'hFA00);
        waitDrain();

        lz_en = 1'b0;
        applyStimulus(16'h1111);
        pushFrame(16'h1111);
        waitDrain();
        waitDen(4'b0010);
        applyStimulus(16'h9999);
        checkOutput("tear_pend_set", pending, 1'b1);
        pushExp(4'b0100, 4'h1, 1'b0, 1'b0);
        pushExp(4'b1000, 4'h1, 1'b0, 1'b0);
        pushFrame(16'h9999);
        waitDrain();
        checkOutput("tear_pend_clr", pending, 1'b0);

        pushFrame(16'h5678);
        waitDen(4'b0000);
        tick();
        bcd_data = 16'h5678;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        checkOutput("coin_fd", frame_done, 1'b1);
        checkOutput("coin_pend", pending, 1'b0);
        waitDrain();
        checkOutput("coin_pend_after", pending, 1'b0);

        waitDen(4'b0100);
        applyStimulus(16'h4321);
        checkOutput("mid_pend_set", pending, 1'b1);
        rst_n    = 1'b0;
        bcd_data = 16'h7777;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        checkOutput("mid_rst_den", dig_en, 4'b0000);
        checkOutput("mid_rst_bcd", bcd_out, 4'hF);
        checkOutput("mid_rst_pend", pending, 1'b0);
        checkOutput("mid_rst_fd", frame_done, 1'b0);
        tick();
        tick();
        pushFrame(16'h0000);
        rst_n = 1'b1;
        tick();
        checkOutput("mid_rel1_den", dig_en, 4'b0000);
        checkOutput("mid_rel1_fd", frame_done, 1'b0);
        tick();
        checkOutput("mid_rel2_den", dig_en, 4'b0001);
        checkOutput("mid_rel2_bcd", bcd_out, 4'h0);
        checkOutput("mid_rel2_fd", frame_done, 1'b1);
        waitDrain();
        checkOutput("mid_pend_after", pending, 1'b0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, DISP-phase length per digit in clk cycles (>=1).
REQ-003 SHALL have parameter BLANK_CYC, default 500, anti-ghost blank length per digit in clk cycles (>=1).
REQ-004 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port load  input  1  one-cycle write strobe for bcd_data.
REQ-007 SHALL have port bcd_data  input  4*NUM_DIGITS  packed BCD; nibble k drives digit k; digit 0 is least significant (rightmost).
REQ-008 SHALL have port lz_en  input  1  leading-zero suppression enable; sampled per digit.
REQ-009 SHALL have port bcd_out  output  4  code to the downstream seven-segment decoder; 4'hF = blank.
REQ-010 SHALL have port dig_en  output  NUM_DIGITS  one-hot active-high digit enable, or all-zero.
REQ-011 SHALL have port pending  output  1  high while loaded data awaits frame commit.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse marking the start of each frame.

Function
REQ-013 SHALL implement a two-state FSM, DISP and BLANK, with phase counter cnt and digit index idx.
REQ-014 In DISP, cnt SHALL count 0..SCAN_DIV-1; at cnt==SCAN_DIV-1 the FSM SHALL move to BLANK with cnt=0.
REQ-015 In BLANK, cnt SHALL count 0..BLANK_CYC-1; at cnt==BLANK_CYC-1 the FSM SHALL move to DISP with cnt=0 and idx=(idx+1) mod NUM_DIGITS.
REQ-016 Digit period SHALL be SCAN_DIV+BLANK_CYC cycles; frame period SHALL be NUM_DIGITS*(SCAN_DIV+BLANK_CYC) cycles.
REQ-017 All outputs SHALL be registered, reflecting the FSM state held in the same cycle.
REQ-018 In DISP: dig_en SHALL be one-hot bit idx, and bcd_out SHALL be active nibble idx or 4'hF if suppressed.
REQ-019 In BLANK: dig_en SHALL be all-zero and bcd_out SHALL be 4'hF.
REQ-020 load=1 SHALL capture bcd_data into shadow register and set pending=1; a later load SHALL overwrite shadow (last write wins).
REQ-021 A commit edge is the BLANK->DISP transition into idx=0; at a commit edge with pending=1, active SHALL take shadow and pending SHALL clear.
REQ-022 Active data SHALL change only at commit edges; no frame SHALL show digits from two different loads.
REQ-023 If load coincides with a commit edge, active SHALL take bcd_data directly, shadow SHALL take bcd_data, and pending SHALL be 0 next cycle.
REQ-024 frame_done SHALL be 1 exactly during the first DISP cycle of idx 0, every frame, whether or not a commit occurred.
REQ-025 With lz_en=1, digit k (k>=1) SHALL be suppressed when active nibbles k..NUM_DIGITS-1 are all 4'h0.
REQ-026 Digit 0 SHALL never be suppressed.
REQ-027 Nibbles 4'hA..4'hF SHALL pass to bcd_out unmodified; they count as non-zero for suppression.

Reset
REQ-028 While rst_n=0 at a clock edge: state=BLANK, idx=NUM_DIGITS-1, cnt=0, active=0, shadow=0, pending=0.
REQ-029 Reset output values SHALL be: dig_en=0, bcd_out=4'hF, frame_done=0.
REQ-030 Reset SHALL take priority over load and over any FSM transition, including when asserted mid-DISP or mid-BLANK.
REQ-031 After release, the first commit edge SHALL occur BLANK_CYC cycles later, with frame_done pulsing and digit 0 showing 0.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=2)
REQ-032 Reset scenario: rst_n low 3 cycles -> dig_en=0000, bcd_out=F; after release, 2 cycles later -> dig_en=0001, bcd_out=0, frame_done=1 for one cycle.
REQ-033 Scan-order scenario: load 16'h1234, lz_en=0 -> after next frame_done, each digit shows 4 cycles then 2 blank cycles. Required output sequence: dig_en 0001/4, 0010/3, 0100/2, 1000/1, with 0000/F between digits; frame repeats every 24 cycles.
REQ-034 Leading-zero scenario: lz_en=1, load 16'h0050 -> digits 3,2 show F, digit 1 shows 5, digit 0 shows 0. Then load 16'h0000 -> only digit 0 shows 0. Then load 16'h0A00 -> digit 2 shows A, digit 1 shows 0.
REQ-035 No-tearing scenario: load 16'h1111; mid-frame (during digit 1) load 16'h9999 -> pending=1 and digits 2,3 still show 1. Next frame_done -> all digits show 9 and pending=0.
REQ-036 Coincident-load scenario: load 16'h5678 on the commit edge -> that same frame shows 8,7,6,5 and pending stays 0.
REQ-037 Mid-operation reset scenario: assert rst_n=0 during DISP of digit 2 -> next cycle outputs dig_en=0, bcd_out=F, pending=0, and the REQ-032 release sequence repeats.
